// File: rtl/pot_scan_sched.sv
// Round-robin A2D scan scheduler for the slide-pot channels with a priority (volume) slot,
// per-channel result registers and a sticky conversion-timeout flag.
module pot_scan_sched #(
  parameter int NUM_CH   = 6,
  parameter int INTERVAL = 1024,
  parameter int TIMEOUT  = 4096,
  parameter int PRI_CH   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pri_req,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          res,
  input  logic                 err_clr,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  output logic [NUM_CH*12-1:0] pot_vals,
  output logic                 upd_vld,
  output logic [2:0]           upd_idx,
  output logic                 err
);

  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    WAIT_INT,
    START,
    WAIT_CMPLT
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] int_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    ptr;
  logic          pri_pend;
  logic          pri_cur;

  logic          load;
  logic          done;
  logic          tmo;
  logic          use_pri;

  // load: last idle cycle, channel is latched here so chnnl is stable from strt_cnv onward
  always_comb begin
    load      = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    use_pri   = pri_pend | pri_req;
    state_nxt = state;
    case (state)
      WAIT_INT: begin
        if (en && (int_cnt == IW'(INTERVAL - 1))) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = WAIT_CMPLT;
      end
      WAIT_CMPLT: begin
        // completion has priority over a coincident terminal count
        if (cnv_cmplt) begin
          done      = 1'b1;
          state_nxt = WAIT_INT;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = WAIT_INT;
        end
      end
      default: begin
        state_nxt = WAIT_INT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_INT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if ((state == WAIT_INT) && en && !load) begin
        int_cnt <= int_cnt + 1'b1;
      end else begin
        int_cnt <= '0;
      end
      if (state == WAIT_CMPLT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      pri_pend <= 1'b0;
      pri_cur  <= 1'b0;
      ptr      <= '0;
    end else begin
      strt_cnv <= load;
      if (load) begin
        chnnl    <= use_pri ? 3'(PRI_CH) : ptr;
        pri_cur  <= use_pri;
        pri_pend <= 1'b0;
      end else if (pri_req) begin
        pri_pend <= 1'b1;
      end
      if ((done || tmo) && !pri_cur) begin
        ptr <= (ptr == 3'(NUM_CH - 1)) ? '0 : ptr + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_vals <= '0;
      upd_vld  <= 1'b0;
      upd_idx  <= '0;
      err      <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (done && (chnnl == 3'(k))) begin
          pot_vals[12*k +: 12] <= res;
        end
      end
      upd_vld <= done;
      if (done) begin
        upd_idx <= chnnl;
      end
      if (tmo) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pot_scan_sched.sv
// Scoreboard bench for pot_scan_sched: an A2D model answers strt_cnv, a monitor checks every
// strt_cnv and upd_vld against queued expectations.
module tb_pot_scan_sched;

  localparam int NUM_CH   = 6;
  localparam int INTERVAL = 4;
  localparam int TIMEOUT  = 32;
  localparam int PRI_CH   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pri_req = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        err_clr = 1'b0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [71:0] pot_vals;
  logic        upd_vld;
  logic [2:0]  upd_idx;
  logic        err;

  pot_scan_sched #(
    .NUM_CH(NUM_CH),
    .INTERVAL(INTERVAL),
    .TIMEOUT(TIMEOUT),
    .PRI_CH(PRI_CH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pri_req(pri_req),
    .cnv_cmplt(cnv_cmplt),
    .res(res),
    .err_clr(err_clr),
    .strt_cnv(strt_cnv),
    .chnnl(chnnl),
    .pot_vals(pot_vals),
    .upd_vld(upd_vld),
    .upd_idx(upd_idx),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int ch; int gap; } strt_exp_t;
  typedef struct packed { int idx; logic [11:0] val; } upd_exp_t;
  strt_exp_t sq[$];
  upd_exp_t  uq[$];
  int strt_seen = 0;
  int upd_seen = 0;
  int last_strt_cyc = 0;

  // A2D model controls
  int mdl_delay = 11;
  int drop_ch = 7;
  bit inject_stale = 1'b0;
  int last_cmplt_cyc = -10;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ps(input int ch, input int gap);
    strt_exp_t e;
    e.ch = ch;
    e.gap = gap;
    sq.push_back(e);
  endtask

  task automatic pu(input int idx);
    upd_exp_t e;
    e.idx = idx;
    e.val = 12'h100 + 12'(idx);
    uq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_strt(input int n);
    for (int i = 0; i < 300 && strt_seen < n; i++) tick();
    chk("wait_strt_budget", strt_seen >= n, 1);
  endtask

  task automatic wait_upd(input int n);
    for (int i = 0; i < 300 && upd_seen < n; i++) tick();
    chk("wait_upd_budget", upd_seen >= n, 1);
  endtask

  task automatic pulse_pri();
    pri_req = 1'b1;
    tick();
    pri_req = 1'b0;
  endtask

  // completion arrives mdl_delay cycles after the START cycle
  initial begin : a2d_model
    int cnt;
    logic [2:0] ch;
    bit busy;
    bit drop_now;
    busy = 1'b0;
    cnt = 0;
    ch = '0;
    drop_now = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            if (!drop_now) begin
              cnv_cmplt = 1'b1;
              res = 12'h100 + 12'(ch);
              last_cmplt_cyc = cyc;
            end
          end
        end
        if (strt_cnv) begin
          busy = 1'b1;
          cnt = mdl_delay;
          ch = chnnl;
          drop_now = (int'(chnnl) == drop_ch);
          if (inject_stale) begin
            cnv_cmplt = 1'b1;
            res = 12'hBAD;
            inject_stale = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    strt_exp_t se;
    upd_exp_t ue;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (strt_cnv) begin
          strt_seen++;
          chk("strt_expected", sq.size() > 0, 1);
          if (sq.size() > 0) begin
            se = sq.pop_front();
            chk("strt_chnnl", 72'(chnnl), 72'(se.ch));
            if (se.gap > 0) chk("strt_gap", 72'(cyc - last_strt_cyc), 72'(se.gap));
          end
          last_strt_cyc = cyc;
        end
        if (upd_vld) begin
          upd_seen++;
          chk("upd_expected", uq.size() > 0, 1);
          if (uq.size() > 0) begin
            ue = uq.pop_front();
            chk("upd_idx", 72'(upd_idx), 72'(ue.idx));
            chk("upd_slot", 72'(pot_vals[12*ue.idx +: 12]), 72'(ue.val));
            chk("upd_latency", 72'(cyc - last_cmplt_cyc), 72'(1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_strt_cnv", strt_cnv, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_pot_vals", pot_vals, 0);
    chk("rst_upd_vld", upd_vld, 0);
    chk("rst_upd_idx", upd_idx, 0);
    chk("rst_err", err, 0);

    // scan order 0..5,0 then 1,2
    ps(0, 0); pu(0);
    for (int k = 1; k < 6; k++) begin ps(k, 16); pu(k); end
    ps(0, 16); pu(0);
    ps(1, 16); pu(1);
    ps(2, 16); pu(2);
    en = 1'b1;
    rst_n = 1'b1;

    // single priority request during channel 2
    wait_strt(9);
    ps(5, 16); pu(5);
    ps(3, 16); pu(3);
    repeat (3) tick();
    pulse_pri();

    // double request during channel 3 -> one extra conversion
    wait_strt(11);
    ps(5, 16); pu(5);
    ps(4, 16); pu(4);
    ps(5, 16); pu(5);
    ps(0, 16); pu(0);
    repeat (2) tick();
    pulse_pri();
    tick();
    pulse_pri();

    // timeout on channel 3
    wait_strt(15);
    drop_ch = 3;
    ps(1, 16); pu(1);
    ps(2, 16); pu(2);
    ps(3, 16);
    ps(4, 37); pu(4);
    wait_strt(18);
    drop_ch = 7;
    repeat (32) tick();
    chk("err_before_terminal", err, 0);
    tick();
    chk("err_after_timeout", err, 1);
    chk("slot3_unchanged", pot_vals[47:36], 12'h103);
    wait_strt(19);
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 0);

    // enable drop mid-conversion, restart
    ps(5, 16); pu(5);
    wait_strt(20);
    repeat (3) tick();
    en = 1'b0;
    wait_upd(19);
    s0 = strt_seen;
    repeat (100) tick();
    chk("no_strt_while_disabled", strt_seen, s0);
    ps(0, 0); pu(0);
    ps(1, 16);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_restart_early", strt_cnv, 0);
    end
    tick();
    chk("en_restart_strt", strt_cnv, 1);

    // asynchronous reset while channel 1 converts
    wait_upd(20);
    wait_strt(22);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_strt_cnv", strt_cnv, 0);
    chk("midrst_chnnl", chnnl, 0);
    chk("midrst_pot_vals", pot_vals, 0);
    chk("midrst_upd_vld", upd_vld, 0);
    chk("midrst_err", err, 0);
    chk("queues_drained_pre_reset", sq.size() + uq.size(), 0);
    sq.delete();
    uq.delete();
    repeat (2) @(negedge clk);
    inject_stale = 1'b1;
    ps(0, 0); pu(0);
    rst_n = 1'b1;
    wait_upd(21);
    chk("pot_vals_after_reset", pot_vals, 72'h100);

    // completion on the timeout terminal count
    mdl_delay = 32;
    ps(1, 16); pu(1);
    ps(2, 37);
    wait_upd(22);
    chk("collision_err", err, 0);
    chk("collision_slot1", pot_vals[23:12], 12'h101);
    mdl_delay = 11;
    wait_strt(25);
    tick();
    chk("strt_queue_empty", sq.size(), 0);
    chk("upd_queue_empty", uq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
